// File: rtl/regfile_rename_mp.sv
// rtl/regfile_rename_mp.sv - architectural register file with ROB rename-tag tracking, N read / M commit ports
// Optional same-cycle commit-to-read forwarding: define REGFILE_COMMIT_BYPASS_EN.
module regfile_rename_mp #(
    parameter int                REG_NUM   = 32,
    parameter int                REG_W     = 5,
    parameter int                DATA_W    = 32,
    parameter int                TAG_W     = 4,
    parameter logic [TAG_W-1:0]  EMPTY_TAG = '1,
    parameter int                RD_PORTS  = 2,
    parameter int                CM_PORTS  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         clear,
    input  logic [RD_PORTS*REG_W-1:0]    rd_pos,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data,
    output logic [RD_PORTS*TAG_W-1:0]    rd_tag,
    input  logic                         iss_en,
    input  logic [REG_W-1:0]             iss_pos,
    input  logic [TAG_W-1:0]             iss_tag,
    input  logic [CM_PORTS-1:0]          cm_en,
    input  logic [CM_PORTS*REG_W-1:0]    cm_pos,
    input  logic [CM_PORTS*DATA_W-1:0]   cm_data,
    input  logic [CM_PORTS*TAG_W-1:0]    cm_tag,
    output logic [REG_W:0]               busy_cnt
);

    // Register 0 has no storage; it is hardwired to 0 / EMPTY_TAG.
    logic [DATA_W-1:0] data_q [1:REG_NUM-1];
    logic [TAG_W-1:0]  tag_q  [1:REG_NUM-1];
    logic [DATA_W-1:0] data_n [1:REG_NUM-1];
    logic [TAG_W-1:0]  tag_n  [1:REG_NUM-1];
    logic              cm_hit [1:REG_NUM-1];
    logic [REG_W:0]    busy_n;

    // Tag write priority within a cycle: clear > rename > commit tag-clear.
    always_comb begin
        busy_n = '0;
        for (int r = 1; r < REG_NUM; r++) begin
            data_n[r] = data_q[r];
            tag_n[r]  = tag_q[r];
            cm_hit[r] = 1'b0;
            for (int k = 0; k < CM_PORTS; k++) begin
                if (cm_en[k] && cm_pos[k*REG_W +: REG_W] == REG_W'(r)) begin
                    data_n[r] = cm_data[k*DATA_W +: DATA_W];
                    if (cm_tag[k*TAG_W +: TAG_W] == tag_q[r])
                        cm_hit[r] = 1'b1;
                end
            end
            if (cm_hit[r])
                tag_n[r] = EMPTY_TAG;
            if (iss_en && iss_pos == REG_W'(r))
                tag_n[r] = iss_tag;
            if (clear)
                tag_n[r] = EMPTY_TAG;
            busy_n = busy_n + {{REG_W{1'b0}}, (tag_n[r] != EMPTY_TAG)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 1; r < REG_NUM; r++) begin
                data_q[r] <= '0;
                tag_q[r]  <= EMPTY_TAG;
            end
            busy_cnt <= '0;
        end else if (rdy) begin
            for (int r = 1; r < REG_NUM; r++) begin
                data_q[r] <= data_n[r];
                tag_q[r]  <= tag_n[r];
            end
            busy_cnt <= busy_n;
        end
    end

    // Position 0 and out-of-range positions match no entry and keep the defaults.
    always_comb begin
        rd_data = '0;
        rd_tag  = {RD_PORTS{EMPTY_TAG}};
        for (int i = 0; i < RD_PORTS; i++) begin
            for (int r = 1; r < REG_NUM; r++) begin
                if (rd_pos[i*REG_W +: REG_W] == REG_W'(r)) begin
                    rd_data[i*DATA_W +: DATA_W] = data_q[r];
                    rd_tag[i*TAG_W +: TAG_W]    = tag_q[r];
`ifdef REGFILE_COMMIT_BYPASS_EN
                    // Ascending loop lets the youngest qualifying commit port win.
                    for (int k = 0; k < CM_PORTS; k++) begin
                        if (rdy && cm_en[k] && cm_pos[k*REG_W +: REG_W] == REG_W'(r) &&
                            cm_tag[k*TAG_W +: TAG_W] == tag_q[r]) begin
                            rd_data[i*DATA_W +: DATA_W] = cm_data[k*DATA_W +: DATA_W];
                            rd_tag[i*TAG_W +: TAG_W]    = EMPTY_TAG;
                        end
                    end
`endif
                end
            end
        end
    end

endmodule

// File: doc/regfile_rename_mp.md
Name: regfile_rename_mp

Overview:
Parametrised architectural register file with rename-tag tracking for the out-of-order core. It has N combinational read ports for the decoder, one rename (issue) port that records the ROB tag producing each register, and M commit ports from the ROB. It also provides a flush on misprediction and a live count of renamed registers. It replaces the 2-read/1-commit register file, generalising port counts and widths and adding a same-cycle rename/commit priority rule.

Parameters:
REG_NUM, 32, number of architectural registers; register 0 is hardwired.
REG_W, 5, register index width; must satisfy 2^REG_W >= REG_NUM.
DATA_W, 32, data width.
TAG_W, 4, ROB tag width.
EMPTY_TAG, 4'b1111, tag value meaning "no pending producer"; all-ones of TAG_W.
RD_PORTS, 2, number of read ports.
CM_PORTS, 2, number of commit ports; a higher index is a younger commit.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
rdy  in  1  global ready; when low, all state is frozen.
clear  in  1  misprediction flush; clears tags only.
rd_pos  in  RD_PORTS*REG_W  read indices; port i occupies bits [i*REG_W +: REG_W].
rd_data  out  RD_PORTS*DATA_W  read data per port.
rd_tag  out  RD_PORTS*TAG_W  pending tag per port.
iss_en  in  1  rename request.
iss_pos  in  REG_W  destination register of the issued instruction.
iss_tag  in  TAG_W  ROB tag of the issued instruction; never EMPTY_TAG.
cm_en  in  CM_PORTS  commit valid, one bit per port.
cm_pos  in  CM_PORTS*REG_W  commit destination per port.
cm_data  in  CM_PORTS*DATA_W  commit value per port.
cm_tag  in  CM_PORTS*TAG_W  ROB tag of the committing instruction per port.
busy_cnt  out  REG_W+1  number of registers whose tag is not EMPTY_TAG (registered).

Behaviour:
- State: data[REG_NUM], tag[REG_NUM], busy_cnt; all updates on posedge clk.
- Reset (rst=1, regardless of rdy or clear): every data entry = 0, every tag = EMPTY_TAG, busy_cnt = 0. Read outputs reflect this in the cycle following reset.
- rdy=0 and rst=0: no state change. Reads remain live.
- Register 0: its data always reads 0 and its tag always reads EMPTY_TAG. Renames and commits targeting position 0 are ignored.
- Out-of-range positions (>= REG_NUM): reads return 0 / EMPTY_TAG; writes are ignored.
- Commit, port k with cm_en[k]=1:
  - data[cm_pos_k] <= cm_data_k.
  - If tag[cm_pos_k] == cm_tag_k, tag <= EMPTY_TAG; otherwise the tag is kept, because a younger rename owns the register.
- Multiple commit ports to the same position in one cycle: the highest-indexed port wins for data. The tag is cleared if any enabled port's tag matches the current tag.
- Rename with iss_en=1: tag[iss_pos] <= iss_tag. Rename overrides a commit tag-clear to the same position in the same cycle; the commit data write still occurs.
- clear=1 (rst=0, rdy=1):
  - All tags <= EMPTY_TAG and busy_cnt <= 0.
  - The rename in the same cycle is discarded.
  - Commits in the same cycle still write data, since they are architecturally retired.
- Reads are combinational from registered state, with no internal latency. A rename in the same cycle is not visible until the next cycle, so an instruction whose rs equals rd reads the old mapping.
- busy_cnt is the registered count of tags != EMPTY_TAG after the cycle's updates. It is incremented or decremented by the net change and is consistent with the tag array at every cycle.
- Writes to the tag array are priority-ordered within a cycle: rst > clear > rename > commit tag-clear.

Optional Feature:
REGFILE_COMMIT_BYPASS_EN
- Defined: if an enabled commit port writes the read position in the current cycle and its tag equals the current tag of that position, the read port returns that port's cm_data and EMPTY_TAG combinationally. When several ports qualify, the highest index wins. Register 0 is never bypassed.
- Undefined: reads reflect registered state only, so committed values appear one cycle after the commit.

Test Plan:
1. Reset, then read x5 and x0 -> data 0 / tag 15 on both ports; busy_cnt 0.
2. Rename x5 with tag 3; next cycle commit x5 with data 0xDEADBEEF and tag 3 -> the cycle after, read x5 returns 0xDEADBEEF / tag 15 and busy_cnt goes 1 -> 0.
3. Rename x7 with tag 2, later rename x7 with tag 6, then commit x7 with data 0x11 and tag 2 -> data 0x11, tag stays 6, busy_cnt 1.
4. Same cycle: commit x9 (tag 4 matching, data 0x55) and rename x9 with tag 8 -> x9 data 0x55, tag 8. Also: two commit ports to x9 with data 0xA (port 0) and 0xB (port 1) -> data 0xB.
5. Rename x1, x2, x3 with tags 1, 2, 3; assert clear together with a commit of x1 (data 0x77, tag 1) and a rename of x4 with tag 5 -> all tags 15, x1 = 0x77, x4 not renamed, busy_cnt 0. Separately, clear with rdy=0 -> no change.
6. With REGFILE_COMMIT_BYPASS_EN: x5 renamed with tag 3; commit x5 with data 0x42 and tag 3 while rd_pos = 5 -> same-cycle read 0x42 / tag 15. Without the macro -> old data / tag 3 that cycle, then 0x42 / tag 15 the next cycle.
